if_stage_fetch: RTL

Instruction-fetch stage and IF/ID pipeline register of the 32-bit five-stage pipeline. It holds the program counter and a word-addressed instruction memory with a load port. Each cycle it delivers {PC+4, instruction} to the ID stage, whose decoder slices opcode/src/dest fields from the instruction word. It accepts branch redirects and flushes from ID and a freeze from the hazard unit.

---
 rtl/if_stage_fetch_if.sv | 36 +++
 rtl/if_stage_fetch.sv | 86 ++++++++
 2 files changed

// File: rtl/if_stage_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : if_stage_fetch_if
// Purpose  : Control, program-load and IF/ID output bundle of the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
interface if_stage_fetch_if #(
    parameter int IMEM_DEPTH = 64
);
    localparam int c_addr_w = $clog2(IMEM_DEPTH);

    logic                freeze;
    logic                Br_taken;
    logic [31:0]         Br_target;
    logic                IF_flush;
    logic                imem_we;
    logic [c_addr_w-1:0] imem_waddr;
    logic [31:0]         imem_wdata;
    logic [31:0]         PC;
    logic [31:0]         Instruction;
    logic                valid;
    logic [31:0]         pc_cur;

    modport master (
        output freeze, Br_taken, Br_target, IF_flush,
        output imem_we, imem_waddr, imem_wdata,
        input  PC, Instruction, valid, pc_cur
    );

    modport slave (
        input  freeze, Br_taken, Br_target, IF_flush,
        input  imem_we, imem_waddr, imem_wdata,
        output PC, Instruction, valid, pc_cur
    );
endinterface
`default_nettype wire

// File: rtl/if_stage_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_stage_fetch
// Purpose  : PC register, word-addressed instruction memory and IF/ID register.
// Revision : 1.0 - initial release
// ============================================================================
module if_stage_fetch #(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  wire             clk,
    input  wire             rst,
    if_stage_fetch_if.slave bus
);
    localparam int          c_addr_w  = $clog2(IMEM_DEPTH);
    localparam logic [31:0] c_pc_step = 32'd4;
    localparam logic [31:0] c_align   = 32'hFFFF_FFFC;

    logic [31:0]         imem_q [IMEM_DEPTH];

    logic [31:0]         pc_cur_q, pc_cur_d;
    logic [31:0]         pc_q,     pc_d;
    logic [31:0]         instr_q,  instr_d;
    logic                valid_q,  valid_d;

    logic [c_addr_w-1:0] w_rd_idx;
    logic [31:0]         w_rd_data;
    logic [31:0]         w_pc_plus4;

    // Upper PC bits are dropped so fetch wraps modulo the memory depth.
    assign w_rd_idx   = pc_cur_q[c_addr_w+1:2];
    assign w_rd_data  = imem_q[w_rd_idx];
    assign w_pc_plus4 = pc_cur_q + c_pc_step;

    // Program-load port; a same-index fetch this cycle still sees the old word.
    always_ff @(posedge clk) begin
        if (bus.imem_we) begin
            imem_q[bus.imem_waddr] <= bus.imem_wdata;
        end
    end

    always_comb begin
        pc_cur_d = pc_cur_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        if (!bus.freeze) begin
            if (bus.Br_taken) begin
                pc_cur_d = bus.Br_target & c_align;
                pc_d     = 32'd0;
                instr_d  = 32'd0;
                valid_d  = 1'b0;
            end else if (bus.IF_flush) begin
                pc_cur_d = w_pc_plus4;
                pc_d     = 32'd0;
                instr_d  = 32'd0;
                valid_d  = 1'b0;
            end else begin
                pc_cur_d = w_pc_plus4;
                pc_d     = w_pc_plus4;
                instr_d  = w_rd_data;
                valid_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_cur_q <= RESET_PC;
            pc_q     <= 32'd0;
            instr_q  <= 32'd0;
            valid_q  <= 1'b0;
        end else begin
            pc_cur_q <= pc_cur_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.PC          = pc_q;
    assign bus.Instruction = instr_q;
    assign bus.valid       = valid_q;
    assign bus.pc_cur      = pc_cur_q;
endmodule
`default_nettype wire
